// File: rtl/key_multi_decoder_pkg.sv
// Shared scan-code constants and repeat-state type for the PS/2 key decoder.
// Holds the counter-width helper used to size the typematic counters.
package kbd_pkg;

  localparam int unsigned KEY_W = 9;

  localparam logic [KEY_W-1:0] KEY_SPACE = 9'h029;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 9'h16B;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 9'h174;
  localparam logic [KEY_W-1:0] KEY_UP    = 9'h175;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_multi_decoder_if.sv
// Scan-code input bundle and per-key result bundle of the key decoder.
// master: keyboard side (drives keyCode/make/brakee); slave: decoder.
interface key_multi_decoder_if #(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned KEY_W    = 9
);

  logic [KEY_W-1:0]    keyCode;
  logic                make;
  logic                brakee;
  logic [NUM_KEYS-1:0] keyIsPressed;
  logic [NUM_KEYS-1:0] keyPressPulse;
  logic [NUM_KEYS-1:0] keyReleasePulse;
  logic [NUM_KEYS-1:0] keyToggle;
  logic [NUM_KEYS-1:0] keyRepeatPulse;
  logic [NUM_KEYS-1:0] keyActionPulse;
  logic                anyPressed;

  modport master (
    output keyCode,
    output make,
    output brakee,
    input  keyIsPressed,
    input  keyPressPulse,
    input  keyReleasePulse,
    input  keyToggle,
    input  keyRepeatPulse,
    input  keyActionPulse,
    input  anyPressed
  );

  modport slave (
    input  keyCode,
    input  make,
    input  brakee,
    output keyIsPressed,
    output keyPressPulse,
    output keyReleasePulse,
    output keyToggle,
    output keyRepeatPulse,
    output keyActionPulse,
    output anyPressed
  );

endinterface

// File: rtl/key_multi_decoder_repeat_channel.sv
// One tracked key: match, level, edge pulses, toggle and typematic repeat.
// Ports: clk/reset, i_key_code/i_make/i_brakee in; o_* per-key results out.
module key_repeat_channel
  import kbd_pkg::*;
#(
  parameter int unsigned       CODE_W        = 9,
  parameter logic [CODE_W-1:0] KEY_VALUE     = '0,
  parameter bit                REPEAT_EN     = 1'b1,
  parameter int unsigned       REPEAT_DELAY  = 25_000_000,
  parameter int unsigned       REPEAT_PERIOD = 5_000_000,
  parameter int unsigned       CNT_W         = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] i_key_code,
  input  logic              i_make,
  input  logic              i_brakee,
  output logic              o_pressed,
  output logic              o_press_pulse,
  output logic              o_release_pulse,
  output logic              o_toggle,
  output logic              o_repeat_pulse,
  output logic              o_action_pulse
);

  logic w_match;
  logic w_press;
  logic w_release;
  logic w_rpt;
  logic r_pressed;
  logic r_dly;
  logic r_toggle;

  assign w_match = (i_key_code == KEY_VALUE);

  // brakee has priority over make in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pressed <= 1'b0;
      r_dly     <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      if (w_match && i_brakee) begin
        r_pressed <= 1'b0;
      end else if (w_match && i_make) begin
        r_pressed <= 1'b1;
      end
      r_dly    <= r_pressed;
      r_toggle <= r_toggle ^ w_press;
    end
  end

  assign w_press   = r_pressed & ~r_dly;
  assign w_release = ~r_pressed & r_dly;

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam logic [CNT_W-1:0] DLY_LAST =
        CNT_W'(REPEAT_DELAY - 1);
      localparam logic [CNT_W-1:0] PER_LAST =
        CNT_W'(REPEAT_PERIOD - 1);

      rpt_state_t       r_state;
      rpt_state_t       w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_fire;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      // Counter value in DELAY is (cycles since press cycle - 1),
      // so the last count lands exactly REPEAT_DELAY after it.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        if (!r_pressed) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          unique case (r_state)
            IDLE: begin
              if (w_press) begin
                w_state_nxt = DELAY;
                w_cnt_nxt   = '0;
              end
            end
            DELAY: begin
              if (r_cnt == DLY_LAST) begin
                w_fire      = 1'b1;
                w_state_nxt = REPEAT;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end
            REPEAT: begin
              if (r_cnt == PER_LAST) begin
                w_fire    = 1'b1;
                w_cnt_nxt = '0;
              end else begin
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end
            default: begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          endcase
        end
      end

      assign w_rpt = w_fire;
    end else begin : g_norpt
      assign w_rpt = 1'b0;
    end
  endgenerate

  assign o_pressed       = r_pressed;
  assign o_press_pulse   = w_press;
  assign o_release_pulse = w_release;
  assign o_toggle        = r_toggle;
  assign o_repeat_pulse  = w_rpt;
  assign o_action_pulse  = w_press | w_rpt;

endmodule

// File: rtl/key_multi_decoder.sv
// Multi-key PS/2 decoder: NUM_KEYS independent key channels + anyPressed.
// Ports: clk, reset (sync, active-high), bus (slave side of the key bundle).
module key_multi_decoder #(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned KEY_W    = 9,
  parameter logic [NUM_KEYS*KEY_W-1:0] KEY_VALUES = {
    kbd_pkg::KEY_UP,
    kbd_pkg::KEY_RIGHT,
    kbd_pkg::KEY_LEFT,
    kbd_pkg::KEY_SPACE
  },
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input logic                 clk,
  input logic                 reset,
  key_multi_decoder_if.slave  bus
);

  localparam int unsigned CNT_W =
    kbd_pkg::cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

  logic [NUM_KEYS-1:0] w_pressed;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_toggle;
  logic [NUM_KEYS-1:0] w_rpt;
  logic [NUM_KEYS-1:0] w_action;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_repeat_channel #(
      .CODE_W       (KEY_W),
      .KEY_VALUE    (KEY_VALUES[g*KEY_W +: KEY_W]),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .i_key_code     (bus.keyCode),
      .i_make         (bus.make),
      .i_brakee       (bus.brakee),
      .o_pressed      (w_pressed[g]),
      .o_press_pulse  (w_press[g]),
      .o_release_pulse(w_release[g]),
      .o_toggle       (w_toggle[g]),
      .o_repeat_pulse (w_rpt[g]),
      .o_action_pulse (w_action[g])
    );
  end

  assign bus.keyIsPressed    = w_pressed;
  assign bus.keyPressPulse   = w_press;
  assign bus.keyReleasePulse = w_release;
  assign bus.keyToggle       = w_toggle;
  assign bus.keyRepeatPulse  = w_rpt;
  assign bus.keyActionPulse  = w_action;
  assign bus.anyPressed      = |w_pressed;

endmodule

// File: tb/tb_key_multi_decoder.sv
// Bench for key_multi_decoder: directed scenarios plus random scan codes,
// checked every cycle against a hold-age model of each key.
module tb_key_multi_decoder;

  localparam int DLY = 10;
  localparam int PER = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  key_multi_decoder_if #(.NUM_KEYS(2), .KEY_W(9)) bus ();

  key_multi_decoder #(
    .NUM_KEYS     (2),
    .KEY_W        (9),
    .KEY_VALUES   ({9'h16B, 9'h029}),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  // Model: each key has a level, last cycle's level, a press count
  // parity (toggle) and an age = cycles since its press-pulse cycle.
  logic [8:0] kv [2];
  int m_lvl [2];
  int m_prev [2];
  int m_tog [2];
  int m_age [2];

  initial begin
    logic [1:0] e_pr, e_pp, e_rp, e_tg, e_rep;
    kv[0] = 9'h029;
    kv[1] = 9'h16B;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_prev[i] = 0; m_tog[i] = 0; m_age[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          m_lvl[i] = 0; m_prev[i] = 0; m_tog[i] = 0; m_age[i] = 0;
        end else begin
          if (m_lvl[i] == 1 && m_prev[i] == 0) m_tog[i] ^= 1;
          m_prev[i] = m_lvl[i];
          if (bus.keyCode == kv[i]) begin
            if (bus.brakee) m_lvl[i] = 0;
            else if (bus.make) m_lvl[i] = 1;
          end
          if (m_lvl[i] == 1 && m_prev[i] == 0) m_age[i] = 0;
          else if (m_lvl[i] == 1) m_age[i]++;
          else m_age[i] = 0;
        end
      end
      #2;
      for (int i = 0; i < 2; i++) begin
        e_pr[i] = (m_lvl[i] == 1);
        e_pp[i] = (m_lvl[i] == 1 && m_prev[i] == 0);
        e_rp[i] = (m_lvl[i] == 0 && m_prev[i] == 1);
        e_tg[i] = (m_tog[i] == 1);
        e_rep[i] = (m_lvl[i] == 1) && (m_age[i] >= DLY) &&
                   ((m_age[i] - DLY) % PER == 0);
      end
      chk("m_pressed", 32'(bus.keyIsPressed), 32'(e_pr));
      chk("m_press", 32'(bus.keyPressPulse), 32'(e_pp));
      chk("m_release", 32'(bus.keyReleasePulse), 32'(e_rp));
      chk("m_toggle", 32'(bus.keyToggle), 32'(e_tg));
      chk("m_repeat", 32'(bus.keyRepeatPulse), 32'(e_rep));
      chk("m_action", 32'(bus.keyActionPulse), 32'(e_pp | e_rep));
      chk("m_any", 32'(bus.anyPressed), 32'(|e_pr));
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.make = 1'b0;
    bus.brakee = 1'b0;
    reset = 1'b1;
    go();
    reset = 1'b0;
  endtask

  task automatic press(input logic [8:0] c);
    bus.keyCode = c;
    bus.make = 1'b1;
    go();
    bus.make = 1'b0;
  endtask

  initial begin
    bus.keyCode = '0;
    bus.make = 1'b0;
    bus.brakee = 1'b0;
    go();
    go();
    chk("rst_pressed", 32'(bus.keyIsPressed), 32'h0);
    chk("rst_toggle", 32'(bus.keyToggle), 32'h0);
    reset = 1'b0;

    // A: press 029, hold 30 cycles, second make at edge t+13
    press(9'h029);
    chk("A_press", 32'(bus.keyPressPulse), 32'h1);
    chk("A_level", 32'(bus.keyIsPressed), 32'h1);
    chk("A_act1", 32'(bus.keyActionPulse), 32'h1);
    chk("A_any", 32'(bus.anyPressed), 32'h1);
    chk("A_tog1", 32'(bus.keyToggle), 32'h0);
    for (int k = 2; k <= 30; k++) begin
      go();
      bus.make = 1'b0;
      if (k == 2) chk("A_tog2", 32'(bus.keyToggle), 32'h1);
      if (k == 14) chk("A_nopp", 32'(bus.keyPressPulse), 32'h0);
      if (k == 15) chk("A_tog15", 32'(bus.keyToggle), 32'h1);
      if (k inside {11, 15, 19, 23, 27})
        chk("A_rep", 32'(bus.keyRepeatPulse), 32'h1);
      else
        chk("A_norep", 32'(bus.keyRepeatPulse), 32'h0);
      if (k == 13) bus.make = 1'b1;
    end

    // B: release at edge t+17
    do_reset();
    press(9'h029);
    for (int k = 2; k <= 22; k++) begin
      go();
      bus.brakee = 1'b0;
      if (k == 15) chk("B_rep15", 32'(bus.keyRepeatPulse), 32'h1);
      if (k == 18) begin
        chk("B_rel", 32'(bus.keyReleasePulse), 32'h1);
        chk("B_lvl", 32'(bus.keyIsPressed), 32'h0);
      end
      if (k == 19) begin
        chk("B_norep", 32'(bus.keyRepeatPulse), 32'h0);
        chk("B_tog", 32'(bus.keyToggle), 32'h1);
      end
      if (k == 17) bus.brakee = 1'b1;
    end

    // C: two keys 3 cycles apart; then make+brakee together on 16B
    do_reset();
    press(9'h029);
    for (int k = 2; k <= 22; k++) begin
      go();
      bus.make = 1'b0;
      bus.brakee = 1'b0;
      if (k == 11) chk("C_r11", 32'(bus.keyRepeatPulse), 32'h1);
      if (k == 14) chk("C_r14", 32'(bus.keyRepeatPulse), 32'h2);
      if (k == 15) chk("C_r15", 32'(bus.keyRepeatPulse), 32'h1);
      if (k == 18) chk("C_r18", 32'(bus.keyRepeatPulse), 32'h2);
      if (k == 21) chk("C_mkbk", 32'(bus.keyIsPressed), 32'h1);
      if (k == 3) begin
        bus.keyCode = 9'h16B;
        bus.make = 1'b1;
      end
      if (k == 20) begin
        bus.keyCode = 9'h16B;
        bus.make = 1'b1;
        bus.brakee = 1'b1;
      end
    end

    // D: reset at edge t+12 mid-hold, key left down, then fresh make
    do_reset();
    press(9'h029);
    for (int k = 2; k <= 27; k++) begin
      go();
      reset = 1'b0;
      bus.make = 1'b0;
      if (k == 13) begin
        chk("D_lvl", 32'(bus.keyIsPressed), 32'h0);
        chk("D_tog", 32'(bus.keyToggle), 32'h0);
        chk("D_any", 32'(bus.anyPressed), 32'h0);
        chk("D_pp", 32'(bus.keyPressPulse), 32'h0);
      end
      if (k > 13 && k < 27)
        chk("D_quiet", 32'(bus.keyRepeatPulse), 32'h0);
      if (k == 27) chk("D_fresh", 32'(bus.keyPressPulse), 32'h1);
      if (k == 12) reset = 1'b1;
      if (k == 26) bus.make = 1'b1;
    end

    // Random traffic checked by the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      go();
      case ($urandom_range(0, 3))
        0, 3: bus.keyCode = 9'h029;
        1: bus.keyCode = 9'h16B;
        default: bus.keyCode = 9'($urandom);
      endcase
      bus.make = ($urandom_range(0, 99) < 30);
      bus.brakee = ($urandom_range(0, 99) < 8);
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
    bus.make = 1'b0;
    bus.brakee = 1'b0;
    go();
    go();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
